// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle of the direct-mapped data cache.
// The cache uses the slave modport; the pipeline/memory model drives the master side.
interface dcache_controller_if #(
  parameter int LINE_BITS = 256
);
  logic                 cpu_req_i;
  logic                 cpu_we_i;
  logic [31:0]          cpu_addr_i;
  logic [31:0]          cpu_data_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with a line-wide
// request/acknowledge memory port and a pipeline stall output.
module dcache_controller #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input logic               clk_i,
  input logic               rst_i,
  dcache_controller_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WORDS  = LINE_BITS / 32;
  localparam int WSEL_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILL    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [NUM_LINES-1:0]   dirty_q, dirty_d;
  logic [LINE_BITS-1:0]   data_q [NUM_LINES];
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];

  logic [IDX_W-1:0]       idx_s;
  logic [TAG_W-1:0]       tag_s;
  logic [WSEL_W-1:0]      word_s;
  logic [LINE_BITS-1:0]   cur_line_s;
  logic [TAG_W-1:0]       cur_tag_s;
  logic                   hit_s;
  logic                   line_we_s;
  logic                   tag_we_s;
  logic [LINE_BITS-1:0]   line_wdata_s;
  logic [31:0]            cpu_data_s;
  logic                   cpu_stall_s;
  logic                   mem_enable_s;
  logic                   mem_write_s;
  logic [31:0]            mem_addr_s;
  logic [LINE_BITS-1:0]   mem_data_s;
  logic                   unused_s;

  function automatic logic [31:0] get_word(input logic [LINE_BITS-1:0] line,
                                           input logic [WSEL_W-1:0]    sel);
    return line[32*int'(sel) +: 32];
  endfunction

  function automatic logic [LINE_BITS-1:0] put_word(input logic [LINE_BITS-1:0] line,
                                                    input logic [WSEL_W-1:0]    sel,
                                                    input logic [31:0]          word);
    logic [LINE_BITS-1:0] res;
    res = line;
    res[32*int'(sel) +: 32] = word;
    return res;
  endfunction

  // The stalled pipeline holds the address for the whole miss, so it is decoded directly.
  assign idx_s      = bus.cpu_addr_i[OFF_W +: IDX_W];
  assign tag_s      = bus.cpu_addr_i[31 -: TAG_W];
  assign word_s     = bus.cpu_addr_i[2 +: WSEL_W];
  assign cur_line_s = data_q[idx_s];
  assign cur_tag_s  = tag_q[idx_s];
  assign hit_s      = valid_q[idx_s] && (cur_tag_s == tag_s);
  assign unused_s   = ^bus.cpu_addr_i[1:0];

  // Next-state, storage update and output decode.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    line_we_s    = 1'b0;
    tag_we_s     = 1'b0;
    line_wdata_s = '0;
    cpu_data_s   = 32'd0;
    cpu_stall_s  = 1'b0;
    mem_enable_s = 1'b0;
    mem_write_s  = 1'b0;
    mem_addr_s   = 32'd0;
    mem_data_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req_i) begin
          if (hit_s) begin
            if (bus.cpu_we_i) begin
              line_we_s      = 1'b1;
              line_wdata_s   = put_word(cur_line_s, word_s, bus.cpu_data_i);
              dirty_d[idx_s] = 1'b1;
            end else begin
              cpu_data_s = get_word(cur_line_s, word_s);
            end
          end else begin
            cpu_stall_s = 1'b1;
            if (valid_q[idx_s] && dirty_q[idx_s]) begin
              state_d = S_WRITEBACK;
            end else begin
              state_d = S_ALLOCATE;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        cpu_stall_s  = 1'b1;
        mem_enable_s = 1'b1;
        mem_write_s  = 1'b1;
        mem_addr_s   = {cur_tag_s, idx_s, {OFF_W{1'b0}}};
        mem_data_s   = cur_line_s;
        if (bus.mem_ack_i) begin
          state_d = S_ALLOCATE;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        cpu_stall_s  = 1'b1;
        mem_enable_s = 1'b1;
        mem_addr_s   = {bus.cpu_addr_i[31:OFF_W], {OFF_W{1'b0}}};
        if (bus.mem_ack_i) begin
          line_we_s      = 1'b1;
          tag_we_s       = 1'b1;
          line_wdata_s   = bus.mem_data_i;
          valid_d[idx_s] = 1'b1;
          dirty_d[idx_s] = 1'b0;
          state_d        = S_REFILL;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_REFILL: begin
        cpu_stall_s = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cpu_data_o   = cpu_data_s;
  assign bus.cpu_stall_o  = cpu_stall_s;
  assign bus.mem_enable_o = mem_enable_s;
  assign bus.mem_write_o  = mem_write_s;
  assign bus.mem_addr_o   = mem_addr_s;
  assign bus.mem_data_o   = mem_data_s;

  // Control state: FSM and per-line valid/dirty bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify their contents.
  always_ff @(posedge clk_i) begin
    if (line_we_s) begin
      data_q[idx_s] <= line_wdata_s;
    end
    if (tag_we_s) begin
      tag_q[idx_s] <= tag_s;
    end
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache sitting between the MEM stage and off-chip data memory.
- Generates the stall signal that freezes the PC and pipeline registers while a miss is serviced.
- Memory side is a 256-bit line-wide request/acknowledge port.
- Contains its own tag, valid, dirty and data storage.

Parameters:
- NUM_LINES, 32, number of cache lines; index width = log2(NUM_LINES) = 5.
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width 5.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- cpu_req_i  input  1  MEM stage issues a load or store this cycle.
- cpu_we_i  input  1  1 = store, 0 = load; valid only with cpu_req_i.
- cpu_addr_i  input  32  byte address; [31:10] tag, [9:5] index, [4:2] word, [1:0] ignored.
- cpu_data_i  input  32  store data.
- cpu_data_o  output  32  load data; valid on a read hit in IDLE.
- cpu_stall_o  output  1  pipeline and PC must hold.
- mem_enable_o  output  1  memory request active.
- mem_write_o  output  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  output  32  line-aligned address, [4:0] = 0.
- mem_data_o  output  256  write-back line data.
- mem_data_i  input  256  fetched line data; valid when mem_ack_i = 1.
- mem_ack_i  input  1  one-cycle completion pulse from memory.

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - All valid and dirty bits cleared; state = IDLE.
  - mem_enable_o = 0, mem_write_o = 0, cpu_stall_o = 0, cpu_data_o = 0 from the following cycle.
  - Tag and data storage contents are don't-care.
  - Reset mid-transaction abandons it; memory must tolerate a dropped enable.
- Hit = valid[index] & (tag[index] == cpu_addr_i[31:10]).
- States:
  - IDLE:
    - cpu_req_i & hit & ~cpu_we_i: cpu_data_o = selected word combinationally, cpu_stall_o = 0.
    - cpu_req_i & hit & cpu_we_i: word written at the edge, dirty[index] set, cpu_stall_o = 0.
    - cpu_req_i & ~hit: cpu_stall_o = 1 combinationally in the same cycle. Next state is WRITEBACK if valid & dirty, else ALLOCATE.
    - ~cpu_req_i: cpu_stall_o = 0, no state change.
  - WRITEBACK:
    - mem_enable_o = 1, mem_write_o = 1.
    - mem_addr_o = {stored tag, index, 5'b0}; mem_data_o = stored line.
    - Held stable until mem_ack_i, then -> ALLOCATE. dirty is not cleared here.
  - ALLOCATE:
    - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu_addr_i[31:5], 5'b0}.
    - On mem_ack_i: line <= mem_data_i, tag updated, valid = 1, dirty = 0; -> REFILL.
  - REFILL:
    - One cycle with mem_enable_o = 0; -> IDLE.
    - In IDLE the access now hits and completes normally (a store then sets dirty).
- cpu_stall_o = 1 in every non-IDLE state.
- cpu_data_o = 0 whenever not a read hit in IDLE.
- cpu_addr_i, cpu_we_i and cpu_data_i are held stable by the stalled pipeline throughout a miss; the controller does not latch them.
- mem_ack_i is ignored in IDLE and REFILL.
- Clean miss latency: 1 (IDLE detect) + memory latency + 1 (REFILL) cycles of stall, then the hit cycle.
- Dirty miss adds the write-back latency.
- Memory address and data outputs are 0 when mem_enable_o = 0.

Test Plan:
- Reset, then load 0x0000_0040 with memory acking 10 cycles after enable and returning a line whose word 0 = 0xDEAD_BEEF. Expected: stall asserted from the request cycle; mem_addr_o = 0x40 with mem_write_o = 0; after ack, 1 REFILL cycle, then cpu_data_o = 0xDEAD_BEEF with stall low.
- Store 0x1234_5678 to 0x44 (hit on the same line), then load 0x44. Expected: no stall on either; load returns 0x1234_5678.
- Load 0x0000_0440 (same index 2, different tag). Expected: WRITEBACK first with mem_addr_o = 0x40, mem_write_o = 1, and mem_data_o word 1 = 0x1234_5678; then ALLOCATE at 0x440; stall is continuous throughout.
- Load of a line evicted clean (no store). Expected: goes straight to ALLOCATE, no write-back request.
- Assert rst_i during ALLOCATE before ack. Expected: next cycle mem_enable_o = 0, cpu_stall_o = 0; a later ack is ignored; a re-access to the same address misses.
- Spurious mem_ack_i pulse in IDLE with cpu_req_i = 0. Expected: no state change; tags and data unchanged.
